// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: divided clock, edge strobes and quarter-phase
// strobes. A divisor reload takes effect only at a period boundary.
module clock_divider_prog #(
  parameter int unsigned      WIDTH       = 27,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = 27'd10,
  parameter int unsigned      MIN_DIV     = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [1:0]       phase,
  output logic             phase_stb
);

  localparam logic [WIDTH-1:0] MinDiv   = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] ResetDiv = (DEFAULT_DIV < MinDiv) ? MinDiv : DEFAULT_DIV;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             pend_v_q, pend_v_d;
  logic             ack_pend_q, ack_pend_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [1:0]       phase_q, phase_d;
  logic             pstb_q, pstb_d;
  logic             ack_q, ack_d;

  logic [WIDTH-1:0] half, quarter, three_q, div_clamped;
  logic             wrap, apply;

  always_comb begin
    half        = div_act_q >> 1;
    quarter     = div_act_q >> 2;
    three_q     = half + quarter;
    wrap        = (cnt_q == div_act_q - WIDTH'(1));
    div_clamped = (div_in < MinDiv) ? MinDiv : div_in;
    apply       = en && wrap && (div_load || pend_v_q);

    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_v_d   = pend_v_q;
    ack_pend_d = ack_pend_q;
    clk_d      = clk_q;
    phase_d    = phase_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    pstb_d     = 1'b0;
    ack_d      = 1'b0;

    if (div_load) begin
      div_pend_d = div_clamped;
      pend_v_d   = 1'b1;
    end

    if (en) begin
      cnt_d  = wrap ? '0 : cnt_q + WIDTH'(1);
      clk_d  = (cnt_q >= half);
      rise_d = (cnt_q == half);
      fall_d = (cnt_q == '0) && clk_q;
      if (cnt_q < quarter)      phase_d = 2'd0;
      else if (cnt_q < half)    phase_d = 2'd1;
      else if (cnt_q < three_q) phase_d = 2'd2;
      else                      phase_d = 2'd3;
      pstb_d = (cnt_q == '0) || (cnt_q == quarter) || (cnt_q == half) || (cnt_q == three_q);
      // Ack is delayed one enabled edge so it lines up with the new period's cnt=0 outputs.
      ack_d      = ack_pend_q;
      ack_pend_d = apply;
      if (apply) begin
        div_act_d = div_load ? div_clamped : div_pend_q;
        pend_v_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q      <= '0;
      div_act_q  <= ResetDiv;
      div_pend_q <= ResetDiv;
      pend_v_q   <= 1'b0;
      ack_pend_q <= 1'b0;
      clk_q      <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      phase_q    <= 2'd0;
      pstb_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_v_q   <= pend_v_d;
      ack_pend_q <= ack_pend_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      phase_q    <= phase_d;
      pstb_q     <= pstb_d;
      ack_q      <= ack_d;
    end
  end

  assign clk_out   = clk_q;
  assign rise_stb  = rise_q;
  assign fall_stb  = fall_q;
  assign phase     = phase_q;
  assign phase_stb = pstb_q;
  assign div_ack   = ack_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: period-position model checked every cycle, plus
// directed literal expectations at hand-computed edges.
module tb_clock_divider_prog;

  logic        clk_in = 1'b0;
  logic        rst, en, div_load;
  logic [26:0] div_in;
  logic        div_ack, clk_out, rise_stb, fall_stb, phase_stb;
  logic [1:0]  phase;

  int n_checks = 0;
  int n_errors = 0;
  int ack_seen = 0;
  bit chk_en   = 1'b0;

  clock_divider_prog #(.WIDTH(27), .DEFAULT_DIV(27'd10), .MIN_DIV(4)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
    .div_ack(div_ack), .clk_out(clk_out), .rise_stb(rise_stb), .fall_stb(fall_stb),
    .phase(phase), .phase_stb(phase_stb)
  );

  always #5 clk_in = ~clk_in;

  // Model: position within the current period, active/pending divisor.
  int unsigned m_pos, m_div, m_pend;
  bit          m_pv, m_new;
  bit          e_clk, e_rise, e_fall, e_pstb, e_ack;
  int unsigned e_phase;

  function automatic int unsigned quarter_of(int unsigned p, int unsigned d);
    int unsigned s[4];
    s = '{0, d / 4, d / 2, d / 2 + d / 4};
    quarter_of = 0;
    for (int k = 1; k < 4; k++) if (p >= s[k]) quarter_of = k;
  endfunction

  function automatic bit quarter_start(int unsigned p, int unsigned d);
    quarter_start = (p == 0) || (p == d / 4) || (p == d / 2) || (p == d / 2 + d / 4);
  endfunction

  always @(posedge clk_in) begin
    int unsigned req;
    req = (div_in < 4) ? 4 : int'(div_in);
    if (rst) begin
      m_pos = 0; m_div = 10; m_pv = 0; m_new = 0;
      e_clk = 0; e_rise = 0; e_fall = 0; e_pstb = 0; e_ack = 0; e_phase = 0;
    end else if (en) begin
      e_fall  = (m_pos == 0) && e_clk;
      e_rise  = (m_pos == m_div / 2);
      e_clk   = (m_pos >= m_div / 2);
      e_phase = quarter_of(m_pos, m_div);
      e_pstb  = quarter_start(m_pos, m_div);
      e_ack   = m_new;
      m_new   = 0;
      if (m_pos + 1 == m_div) begin
        m_pos = 0;
        if (div_load || m_pv) begin
          m_div = div_load ? req : m_pend;
          m_pv  = 0;
          m_new = 1;
        end
      end else begin
        m_pos = m_pos + 1;
        if (div_load) begin m_pend = req; m_pv = 1; end
      end
    end else begin
      e_rise = 0; e_fall = 0; e_pstb = 0; e_ack = 0;
      if (div_load) begin m_pend = req; m_pv = 1; end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (div_ack === 1'b1) ack_seen++;
    if (chk_en) begin
      check("model clk_out",   clk_out,   e_clk);
      check("model rise_stb",  rise_stb,  e_rise);
      check("model fall_stb",  fall_stb,  e_fall);
      check("model phase",     phase,     e_phase);
      check("model phase_stb", phase_stb, e_pstb);
      check("model div_ack",   div_ack,   e_ack);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic load(input int unsigned d);
    div_in = 27'(d); div_load = 1'b1;
    tick(1);
    div_load = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick(1);
      if (div_ack === 1'b1) got = 1;
    end
    check(name, got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; en = 1'b1; div_load = 1'b0; div_in = '0;
    tick(3);
    chk_en = 1'b1;
    check("reset clk_out", clk_out, 0);
    check("reset phase", phase, 0);
    check("reset div_ack", div_ack, 0);
    check("reset phase_stb", phase_stb, 0);

    // Default divisor 10
    rst = 1'b0;
    tick(1);
    check("edge1 phase_stb", phase_stb, 1);
    check("edge1 clk_out", clk_out, 0);
    check("model pin edge1", e_pstb, 1);
    tick(5);
    check("edge6 rise_stb", rise_stb, 1);
    check("edge6 clk_out", clk_out, 1);
    check("model pin edge6", e_rise, 1);
    tick(5);
    check("edge11 fall_stb", fall_stb, 1);
    check("edge11 clk_out", clk_out, 0);

    // Load 6 while cnt=3
    tick(2);
    base = ack_seen;
    load(6);
    tick(6);
    check("div6 ack not early", div_ack, 0);
    tick(1);
    check("div6 ack", div_ack, 1);
    check("div6 first fall", fall_stb, 1);
    tick(3);
    check("div6 rise after 3", rise_stb, 1);
    check("div6 single ack", ack_seen - base, 1);
    tick(3);
    check("div6 period fall", fall_stb, 1);

    // Clamp 2 -> 4
    base = ack_seen;
    load(2);
    wait_ack("clamp ack timeout");
    tick(2);
    check("clamp rise after 2", rise_stb, 1);
    tick(2);
    check("clamp fall after 4", fall_stb, 1);
    check("clamp single ack", ack_seen - base, 1);

    // Overwrite 20 by 8 within one period
    base = ack_seen;
    load(20);
    load(8);
    wait_ack("overwrite ack timeout");
    tick(4);
    check("div8 rise after 4", rise_stb, 1);
    check("model pin div8", m_div, 8);
    tick(20);
    check("overwrite single ack", ack_seen - base, 1);

    // Odd divisor 7
    load(7);
    wait_ack("div7 ack timeout");
    tick(1);
    check("div7 q1 stb", phase_stb, 1);
    check("div7 q1 phase", phase, 1);
    tick(1);
    check("div7 cnt2 no stb", phase_stb, 0);
    tick(1);
    check("div7 rise", rise_stb, 1);
    check("div7 q2 phase", phase, 2);
    tick(1);
    check("div7 rise one wide", rise_stb, 0);
    check("div7 q3 phase", phase, 3);
    check("div7 q3 stb", phase_stb, 1);
    tick(3);
    check("div7 fall", fall_stb, 1);
    tick(1);
    check("div7 fall one wide", fall_stb, 0);

    // Enable gating mid-high
    tick(2);
    check("gate pre clk_out", clk_out, 1);
    en = 1'b0;
    tick(5);
    check("gate hold clk_out", clk_out, 1);
    check("gate no pstb", phase_stb, 0);
    en = 1'b1;
    tick(3);
    check("gate resume high", clk_out, 1);
    check("gate resume no fall", fall_stb, 0);
    tick(1);
    check("gate resume fall", fall_stb, 1);

    // Load while disabled at last count
    tick(5);
    en = 1'b0;
    load(5);
    tick(2);
    en = 1'b1;
    tick(1);
    check("disabled load no early ack", div_ack, 0);
    tick(1);
    check("disabled load ack", div_ack, 1);
    check("disabled load pstb", phase_stb, 1);

    // Mid-operation reset with pending load
    load(9);
    wait_ack("div9 ack timeout");
    tick(5);
    load(12);
    base = ack_seen;
    rst = 1'b1;
    tick(1);
    check("mid reset clk_out", clk_out, 0);
    check("mid reset phase", phase, 0);
    check("mid reset rise", rise_stb, 0);
    rst = 1'b0;
    tick(6);
    check("post reset rise edge6", rise_stb, 1);
    tick(10);
    check("post reset rise edge16", rise_stb, 1);
    tick(4);
    check("post reset no ack", ack_seen - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
